// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed operands run as magnitudes; the sign fix is folded into the final step.
module div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [2:0]            div_ctrl,
  output logic                  busy,
  output logic                  div_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  is_rem_q, is_rem_d;

  logic                  is_signed, op1_neg, op2_neg, div_zero, overflow;
  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic [DATA_WIDTH:0]   shifted, diff;
  logic                  take;
  logic [DATA_WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix;

  assign is_signed = ~div_ctrl[0];
  assign op1_neg   = is_signed & op1[DATA_WIDTH-1];
  assign op2_neg   = is_signed & op2[DATA_WIDTH-1];
  assign mag1      = op1_neg ? ('0 - op1) : op1;
  assign mag2      = op2_neg ? ('0 - op2) : op2;
  assign div_zero  = (op2 == '0);
  assign overflow  = is_signed & (op1 == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (op2 == '1);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign take     = ~diff[DATA_WIDTH];
  assign rem_next = take ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign quo_next = {quo_q[DATA_WIDTH-2:0], take};
  assign quo_fix  = neg_quo_q ? ('0 - quo_next) : quo_next;
  assign rem_fix  = neg_rem_q ? ('0 - rem_next) : rem_next;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    busy      = 1'b0;
    div_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && div_ctrl[2]) begin
          is_rem_d  = div_ctrl[1];
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          quo_d     = mag1;
          rem_d     = '0;
          dvs_d     = mag2;
          cnt_d     = '0;
          // Divide-by-zero and signed overflow skip iteration entirely.
          if (div_zero) begin
            result_d = div_ctrl[1] ? op1 : '1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = div_ctrl[1] ? '0 : op1;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy  = 1'b1;
        quo_d = quo_next;
        rem_d = rem_next;
        if (cnt_q == CW'(DATA_WIDTH-1)) begin
          cnt_d    = '0;
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        div_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a start in the same cycle.
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table plus hand-written
// flush / reset / restart sequences, results tracked through a scoreboard queue.
module tb_div_seq;

  localparam int W = 32;
  localparam int NV = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [2:0]   div_ctrl;
  logic         busy;
  logic         div_ready;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] last_res;

  typedef struct {
    string        name;
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[NV];

  div_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .op1       (op1),
    .op2       (op2),
    .div_ctrl  (div_ctrl),
    .busy      (busy),
    .div_ready (div_ready),
    .result    (result)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Global watchdog so a stuck design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Drive one start cycle and push the expected result; returns in cycle 1.
  task automatic applyStimulus(input vec_t v);
    op1      = v.a;
    op2      = v.b;
    div_ctrl = v.ctrl;
    start    = 1'b1;
    sb_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
    div_ctrl = 3'($urandom_range(0, 7));
  endtask

  // Wait for div_ready, check latency, busy length, result and pulse width.
  task automatic checkOutput(input vec_t v);
    int n;
    int busy_cnt;
    logic [W-1:0] exp;
    n = 1;
    busy_cnt = 0;
    while (n <= 40 && !div_ready) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({v.name, "_latency"}, W'(n), W'(v.lat));
    check({v.name, "_busy_cycles"}, W'(busy_cnt), W'(v.lat - 1));
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    if (div_ready) begin
      check({v.name, "_result"}, result, exp);
      last_res = exp;
    end
    @(negedge clk);
    check({v.name, "_pulse_width"}, W'(div_ready), W'(0));
    check({v.name, "_result_hold"}, result, exp);
  endtask

  initial begin
    vecs[0]  = '{"divu_100_7",     3'b101, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{"rem_m7_2",       3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[2]  = '{"div_m7_2",       3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{"divu_5_0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[4]  = '{"remu_5_0",       3'b111, 32'd5,          32'd0,          32'd5,          1};
    vecs[5]  = '{"div_ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[6]  = '{"rem_ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[7]  = '{"div_20_m3",      3'b100, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  33};
    vecs[8]  = '{"rem_20_m3",      3'b110, 32'd20,         32'hFFFF_FFFD,  32'd2,          33};
    vecs[9]  = '{"divu_max_1",     3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[10] = '{"remu_max_16",    3'b111, 32'hFFFF_FFFF,  32'h10,         32'hF,          33};
    vecs[11] = '{"div_m5_0",       3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[12] = '{"rem_m5_0",       3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
    vecs[13] = '{"divu_min_max",   3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[14] = '{"remu_min_max",   3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[15] = '{"rem_m100_m7",    3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33};
    vecs[16] = '{"divu_3_10",      3'b101, 32'd3,          32'd10,         32'd0,          33};

    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    op1      = '0;
    op2      = '0;
    div_ctrl = 3'b000;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(busy), W'(0));
    check("reset_ready", W'(div_ready), W'(0));
    check("reset_result", result, '0);
    rst = 1'b0;
    @(negedge clk);

    // A start with div_ctrl[2]=0 is not a divide and must be ignored.
    op1 = 32'd50; op2 = 32'd5; div_ctrl = 3'b001; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("nondiv_busy_c1", W'(busy), W'(0));
    check("nondiv_ready_c1", W'(div_ready), W'(0));
    @(negedge clk);
    check("nondiv_ready_c2", W'(div_ready), W'(0));

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Flush at cycle 10 of a DIVU, with a start in the flush cycles as well.
    begin
      int n;
      op1 = 32'd1000; op2 = 32'd7; div_ctrl = 3'b101; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n < 10) begin @(negedge clk); n++; end
      check("flush_busy_c10", W'(busy), W'(1));
      flush = 1'b1; start = 1'b1; op1 = 32'd77; op2 = 32'd7;
      @(negedge clk);
      check("flush_busy_c11", W'(busy), W'(0));
      check("flush_ready_c11", W'(div_ready), W'(0));
      check("flush_result_c11", result, last_res);
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      check("flush_prio_busy", W'(busy), W'(0));
      check("flush_prio_ready", W'(div_ready), W'(0));
      begin
        vec_t v;
        v = '{"after_flush_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 33};
        applyStimulus(v);
        checkOutput(v);
      end
    end

    // Extra starts during RUN are ignored; a start held through DONE is taken in the following IDLE.
    begin
      int pulses;
      int first_pulse;
      int second_pulse;
      logic [W-1:0] exp;
      pulses = 0; first_pulse = 0; second_pulse = 0;
      op1 = 32'd100; op2 = 32'd7; div_ctrl = 3'b101; start = 1'b1;
      sb_q.push_back(32'd14);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 80; n++) begin
        if (div_ready) begin
          pulses++;
          if (pulses == 1) first_pulse = n;
          if (pulses == 2) second_pulse = n;
          exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
          check($sformatf("restart_result_p%0d", pulses), result, exp);
          last_res = exp;
        end
        if (n == 34) check("restart_busy_c34", W'(busy), W'(0));
        if (n == 35) check("restart_busy_c35", W'(busy), W'(1));
        if (n >= 5 && n <= 7) begin
          start = 1'b1; op1 = $urandom; op2 = 32'd1; div_ctrl = 3'b101;
        end else if (n >= 30 && n <= 34) begin
          start = 1'b1; op1 = 32'd9; op2 = 32'd3; div_ctrl = 3'b101;
          if (n == 30) sb_q.push_back(32'd3);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      check("restart_pulses", W'(pulses), W'(2));
      check("restart_first_cycle", W'(first_pulse), W'(33));
      check("restart_second_cycle", W'(second_pulse), W'(67));
    end

    // Reset mid-RUN clears result and returns to IDLE without a pulse.
    begin
      int n;
      op1 = 32'd100; op2 = 32'd7; div_ctrl = 3'b101; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n < 10) begin @(negedge clk); n++; end
      check("rst_busy_before", W'(busy), W'(1));
      check("rst_result_before", result, last_res);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy", W'(busy), W'(0));
      check("rst_ready", W'(div_ready), W'(0));
      check("rst_result", result, '0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_stays_idle", W'(busy), W'(0));
    end

    check("scoreboard_empty", W'(sb_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
